// File: rtl/alu_ctrl_muldiv.sv
// EX-stage ALU control with an iterative mult/div sequencer owning HI/LO.
// Optional MULDIV_EARLY_OUT_EN: multiply exits once the remaining multiplier bits are zero.
module alu_ctrl_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid,
  input  logic [2:0]       ALUOp,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic [3:0]       ALUControl,
  output logic             md_sel,
  output logic [WIDTH-1:0] md_result,
  output logic             stall,
  output logic             md_busy,
  output logic             md_done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL  = 2'd1;
  localparam logic [1:0] DIV  = 2'd2;
  localparam logic [1:0] FIX  = 2'd3;
  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  always_comb begin
    ALUControl = 4'b0000;
    unique case (ALUOp)
      3'b000: ALUControl = 4'b0010;
      3'b001: ALUControl = 4'b0110;
      3'b011: ALUControl = 4'b0000;
      3'b100: ALUControl = 4'b0001;
      3'b101: ALUControl = 4'b0111;
      3'b110: ALUControl = 4'b0101;
      3'b111: ALUControl = 4'b0011;
      3'b010: begin
        case (funct)
          6'b100000, 6'b100001: ALUControl = 4'b0010;
          6'b100010, 6'b100011: ALUControl = 4'b0110;
          6'b100100: ALUControl = 4'b0000;
          6'b100101: ALUControl = 4'b0001;
          6'b100110: ALUControl = 4'b0011;
          6'b100111: ALUControl = 4'b1100;
          6'b101010: ALUControl = 4'b0111;
          6'b101011: ALUControl = 4'b0101;
          default:   ALUControl = 4'b0000;
        endcase
      end
    endcase
  end

  logic [1:0]         state;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc, mcand;
  logic [WIDTH-1:0]   mplier, rem, quo, dvsr, a_keep;
  logic               neg, rneg, dz;

  logic md_op, idle, sgn, start_mul, start_div;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign md_op = valid && (ALUOp == 3'b010) &&
                 (funct inside {F_MFHI, F_MTHI, F_MFLO, F_MTLO,
                                F_MULT, F_MULTU, F_DIV, F_DIVU});
  assign idle      = (state == IDLE);
  assign stall     = md_op && !idle;
  assign md_busy   = !idle;
  assign md_sel    = md_op && !stall &&
                     (funct == F_MFHI || funct == F_MFLO);
  assign md_result = (funct == F_MFHI) ? hi : lo;

  // funct[0] clear selects the signed variant for both mult and div
  assign sgn       = ~funct[0];
  assign start_mul = md_op && idle && (funct == F_MULT || funct == F_MULTU);
  assign start_div = md_op && idle && (funct == F_DIV || funct == F_DIVU);
  assign a_mag     = (sgn && src_a[WIDTH-1]) ? -src_a : src_a;
  assign b_mag     = (sgn && src_b[WIDTH-1]) ? -src_b : src_b;

  logic [WIDTH-1:0] mplier_nx;
  logic [WIDTH:0]   trial, diff;
  logic             mul_last, last;

  assign mplier_nx = mplier >> 1;
  assign trial     = {rem, quo[WIDTH-1]};
  assign diff      = trial - {1'b0, dvsr};
  assign last      = (cnt == CW'(WIDTH - 1));
`ifdef MULDIV_EARLY_OUT_EN
  assign mul_last  = last || (mplier_nx == '0);
`else
  assign mul_last  = last;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      hi      <= '0;
      lo      <= '0;
      md_done <= 1'b0;
      cnt     <= '0;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      rem     <= '0;
      quo     <= '0;
      dvsr    <= '0;
      a_keep  <= '0;
      neg     <= 1'b0;
      rneg    <= 1'b0;
      dz      <= 1'b0;
    end else begin
      md_done <= 1'b0;
      unique case (state)
        IDLE: begin
          cnt    <= '0;
          neg    <= sgn && (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
          rneg   <= sgn && src_a[WIDTH-1];
          dz     <= (src_b == '0);
          a_keep <= src_a;
          if (start_mul) begin
            state  <= MUL;
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, a_mag};
            mplier <= b_mag;
          end else if (start_div) begin
            state <= DIV;
            rem   <= '0;
            quo   <= a_mag;
            dvsr  <= b_mag;
          end else if (md_op && funct == F_MTHI) begin
            hi <= src_a;
          end else if (md_op && funct == F_MTLO) begin
            lo <= src_a;
          end
        end
        MUL: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier_nx;
          cnt    <= cnt + CW'(1);
          if (mul_last) state <= FIX;
        end
        DIV: begin
          if (!diff[WIDTH]) begin
            rem <= diff[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], 1'b1};
          end else begin
            rem <= trial[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], 1'b0};
          end
          cnt <= cnt + CW'(1);
          if (last) state <= FIX;
        end
        FIX: begin
          state   <= IDLE;
          md_done <= 1'b1;
          if (dvsr == '0 && dz) begin
            lo <= '1;
            hi <= a_keep;
          end else if (dvsr != '0) begin
            lo <= neg  ? -quo : quo;
            hi <= rneg ? -rem : rem;
          end else begin
            {hi, lo} <= neg ? -acc : acc;
          end
        end
      endcase
      // a multiply leaves dvsr cleared so FIX can tell the two apart
      if (start_mul) dvsr <= '0;
      if (start_mul) dz <= 1'b0;
    end
  end
endmodule

// File: tb/tb_alu_ctrl_muldiv.sv
// Directed bench for alu_ctrl_muldiv: decode sweep, mult/div results,
// hazards, reset abort and multiply latency.
module tb_alu_ctrl_muldiv;
  logic        clk = 1'b0;
  logic        reset, valid;
  logic [2:0]  ALUOp;
  logic [5:0]  funct;
  logic [31:0] src_a, src_b;
  logic [3:0]  ALUControl;
  logic        md_sel, stall, md_busy, md_done;
  logic [31:0] md_result, hi, lo;

  int checks = 0;
  int errors = 0;

`ifdef MULDIV_EARLY_OUT_EN
  localparam int ML = 0;
`else
  localparam int ML = 34;
`endif

  alu_ctrl_muldiv #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .valid(valid),
    .ALUOp(ALUOp), .funct(funct),
    .src_a(src_a), .src_b(src_b),
    .ALUControl(ALUControl), .md_sel(md_sel),
    .md_result(md_result), .stall(stall),
    .md_busy(md_busy), .md_done(md_done),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic present(input logic [5:0] f, input logic [31:0] a,
                         input logic [31:0] b);
    valid = 1'b1;
    ALUOp = 3'b010;
    funct = f;
    src_a = a;
    src_b = b;
    #1;
  endtask

  task automatic do_md(input string tag, input logic [5:0] f,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ehi, input logic [31:0] elo,
                       input int lat);
    int c;
    present(f, a, b);
    chk({tag, "_stall0"}, 32'(stall), 32'd0);
    step();
    valid = 1'b0;
    c = 1;
    chk({tag, "_busy1"}, 32'(md_busy), 32'd1);
    while (md_busy && c < 100) begin
      step();
      c++;
    end
    if (lat == 0) chk({tag, "_early"}, 32'(c < 34), 32'd1);
    else chk({tag, "_lat"}, 32'(c), 32'(lat));
    chk({tag, "_done"}, 32'(md_done), 32'd1);
    chk({tag, "_hi"}, hi, ehi);
    chk({tag, "_lo"}, lo, elo);
    step();
    chk({tag, "_done0"}, 32'(md_done), 32'd0);
  endtask

  logic [3:0] op_exp [8] = '{4'h2, 4'h6, 4'h2, 4'h0,
                             4'h1, 4'h7, 4'h5, 4'h3};
  logic [5:0] f_tab [13] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24,
                             6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B,
                             6'h18, 6'h10, 6'h00};
  logic [3:0] f_exp [13] = '{4'h2, 4'h2, 4'h6, 4'h6, 4'h0,
                             4'h1, 4'h3, 4'hC, 4'h7, 4'h5,
                             4'h0, 4'h0, 4'h0};

  initial begin
    int c;
    logic bad;
    reset = 1'b1;
    valid = 1'b0;
    ALUOp = 3'b000;
    funct = 6'b100000;
    src_a = '0;
    src_b = '0;
    step();
    step();
    reset = 1'b0;
    #1;
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_busy", 32'(md_busy), 32'd0);
    chk("rst_done", 32'(md_done), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);

    funct = 6'b100000;
    for (int i = 0; i < 8; i++) begin
      ALUOp = 3'(i);
      #1;
      chk($sformatf("aluop_%0d", i), 32'(ALUControl), 32'(op_exp[i]));
    end
    ALUOp = 3'b010;
    for (int i = 0; i < 13; i++) begin
      funct = f_tab[i];
      #1;
      chk($sformatf("funct_%h", f_tab[i]), 32'(ALUControl),
          32'(f_exp[i]));
    end
    step();

    do_md("mult", 6'b011000, 32'hFFFFFFFE, 32'd3,
          32'hFFFFFFFF, 32'hFFFFFFFA, ML);
    do_md("multu", 6'b011001, 32'hFFFFFFFE, 32'd3,
          32'h00000002, 32'hFFFFFFFA, ML);
    do_md("multu51", 6'b011001, 32'd5, 32'd1,
          32'd0, 32'd5, ML);
    do_md("div", 6'b011010, 32'hFFFFFFF9, 32'd2,
          32'hFFFFFFFF, 32'hFFFFFFFD, 34);
    do_md("divu0", 6'b011011, 32'd100, 32'd0,
          32'd100, 32'hFFFFFFFF, 34);
    do_md("div0", 6'b011010, 32'hFFFFFFFB, 32'd0,
          32'hFFFFFFFB, 32'hFFFFFFFF, 34);
    do_md("divovf", 6'b011010, 32'h80000000, 32'hFFFFFFFF,
          32'd0, 32'h80000000, 34);

    // mflo arriving mid-divide must wait for the new quotient
    present(6'b011010, 32'd100, 32'd7);
    step();
    valid = 1'b0;
    c = 1;
    repeat (4) begin
      step();
      c++;
    end
    present(6'b010010, 32'd0, 32'd0);
    chk("mflo_stall", 32'(stall), 32'd1);
    chk("mflo_sel0", 32'(md_sel), 32'd0);
    bad = 1'b0;
    while (stall && c < 100) begin
      if (md_sel) bad = 1'b1;
      step();
      c++;
    end
    chk("mflo_selwait", 32'(bad), 32'd0);
    chk("mflo_cycle", 32'(c), 32'd34);
    chk("mflo_sel1", 32'(md_sel), 32'd1);
    chk("mflo_result", md_result, 32'd14);
    chk("mfhi_hi", hi, 32'd2);
    valid = 1'b0;
    step();

    // mtlo while busy holds off until the sequencer is idle
    present(6'b011000, 32'd3, 32'd4);
    step();
    present(6'b010011, 32'h55, 32'd0);
    c = 1;
    while (stall && c < 100) begin
      step();
      c++;
    end
    chk("mtlo_hold", lo, 32'd12);
    step();
    valid = 1'b0;
    chk("mtlo_write", lo, 32'h55);

    present(6'b010001, 32'hABCD, 32'd0);
    step();
    valid = 1'b0;
    chk("mthi_write", hi, 32'hABCD);

    // reset during a multiply aborts it without a HI/LO write
    present(6'b011001, 32'd7, 32'd9);
    step();
    valid = 1'b0;
    repeat (9) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_busy", 32'(md_busy), 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    bad = 1'b0;
    repeat (40) begin
      if (md_done) bad = 1'b1;
      step();
    end
    chk("abort_nodone", 32'(bad), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_ctrl_muldiv.md
Name: alu_ctrl_muldiv

Overview:
- Next-generation ALU control for the MIPS datapath, sitting in the EX stage beside the ALU.
- Widens main-control ALUOp to 3 bits so I-type logical and compare ops decode directly.
- Extends R-type funct decode with xor, nor, sltu, addu and subu.
- Adds an iterative multiply/divide sequencer that owns the HI/LO registers and stalls the pipeline while it runs.

Parameters:
WIDTH, 32, datapath width for operands, HI and LO.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  synchronous, active-high reset.
valid  input  1  EX-stage instruction is valid this cycle.
ALUOp  input  3  operation class from the main control unit.
funct  input  6  instruction funct field.
src_a  input  WIDTH  rs operand; dividend or multiplicand.
src_b  input  WIDTH  rt operand; divisor or multiplier.
ALUControl  output  4  ALU operation select (combinational).
md_sel  output  1  EX result must come from md_result (mfhi/mflo).
md_result  output  WIDTH  HI for mfhi, LO for mflo (combinational).
stall  output  1  freeze the pipeline this cycle (combinational).
md_busy  output  1  sequencer is running.
md_done  output  1  one-cycle pulse: HI/LO just updated by mult or div.
hi  output  WIDTH  HI register.
lo  output  WIDTH  LO register.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high. On reset: state IDLE, hi=0, lo=0, md_busy=0, md_done=0. Reset mid-operation aborts the operation with no HI/LO write.
- ALUControl encodings: and 0000, or 0001, add 0010, xor 0011, sltu 0101, sub 0110, slt 0111, nor 1100.
- ALUOp decode: 000 add, 001 sub, 010 decode funct, 011 and, 100 or, 101 slt, 110 sltu, 111 xor.
- funct decode (ALUOp=010):
  - add/addu (100000/100001) -> add.
  - sub/subu (100010/100011) -> sub.
  - 100100 and, 100101 or, 100110 xor, 100111 nor, 101010 slt, 101011 sltu.
  - Any other funct, including all mul/div/move functs -> 0000.
- Mul/div functs: mult 011000, multu 011001, div 011010, divu 011011, mfhi 010000, mthi 010001, mflo 010010, mtlo 010011. A "md-op" is valid && ALUOp==010 && funct is one of these eight.
- md_sel: =1 for mfhi/mflo only when stall=0.
- md_result: = hi for mfhi, otherwise lo.
- stall: =1 iff an md-op is present and state != IDLE.
- FSM states: IDLE, MUL, DIV, FIX.
  - IDLE -> MUL on mult/multu with stall=0. Operands are captured in this same cycle.
  - IDLE -> DIV on div/divu with stall=0. Operands are captured in this same cycle.
  - MUL/DIV run WIDTH iterations (shift-add multiply; restoring divide on magnitudes), then go to FIX.
  - FIX applies sign correction: signed product negated if the operand signs differ; quotient negated if signs differ; remainder takes the dividend's sign. FIX writes hi/lo at its closing edge, then returns to IDLE.
- Timing (start edge = cycle 0): md_busy=1 in cycles 1..WIDTH+1. In cycle WIDTH+2: md_busy=0, md_done=1, hi/lo hold new values. A new start is accepted in that same cycle.
- Results: mult/multu -> {hi,lo} = 2*WIDTH-bit product. div/divu -> lo = quotient, hi = remainder.
- Divide by zero: lo = all ones, hi = src_a. No trap.
- Signed overflow case (most-negative / -1): lo = most-negative value, hi = 0.
- mthi/mtlo with stall=0: write hi/lo from src_a at that clock edge. While busy they stall and do not write.
- A mult or div arriving while busy stalls; it is not queued and not dropped. The pipeline re-presents it.

Optional Feature:
- Macro MULDIV_EARLY_OUT_EN.
- Defined: MUL leaves for FIX as soon as the remaining unprocessed multiplier magnitude bits are all zero, after at least 1 iteration. md_busy and md_done shift earlier accordingly. DIV timing is unchanged.
- Undefined: MUL always takes exactly WIDTH iterations and latency is fixed at WIDTH+2.

Test Plan:
- Decode sweep: ALUOp 000..111 with funct=100000, then ALUOp=010 with every listed funct -> encodings exactly as tabled; funct 011000 -> ALUControl 0000.
- mult, src_a=0xFFFFFFFE (-2), src_b=3, WIDTH=32 -> stall/md_busy for cycles 1..33; cycle 34: md_done=1, hi=0xFFFFFFFF, lo=0xFFFFFFFA. multu with the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- div, src_a=-7 (0xFFFFFFF9), src_b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). divu 100/0 -> lo=0xFFFFFFFF, hi=100.
- Hazards: mflo presented in cycle 5 of a div -> stall=1 and md_sel=0 until cycle 34. In cycle 34, md_sel=1 and md_result equals the new lo. mtlo 0x55 while busy -> lo unchanged; after completion, lo=0x55.
- Reset: assert reset in cycle 10 of a mult -> next cycle md_busy=0, hi=lo=0, md_done never pulses.
- MULDIV_EARLY_OUT_EN defined: multu 5*1 -> md_done well before cycle 34, result hi=0, lo=5. Undefined: md_done exactly at cycle 34.
